data_ram_ctrl: RTL and testbench

- Data-memory responder on the far end of the load/store interface driven by the memory-access pipeline stage.
- Accepts one word-wide request at a time: chip enable, 4-bit byte write enables, address, write data.
- Backs the request with an internal word array and programmable wait states; returns read data and a one-cycle ready pulse.
- Drives a stall request that freezes the pipeline while an access is in flight.

---
 rtl/data_ram_ctrl_pkg.sv | 26 ++
 rtl/data_ram_ctrl_ram_bank_be.sv | 39 +++
 rtl/data_ram_ctrl.sv | 115 +++++++++++
 tb/tb_data_ram_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/data_ram_ctrl_pkg.sv
// rtl/data_ram_ctrl_pkg.sv - shared widths, FSM encodings and lane-mask helper for data_ram_ctrl
package data_ram_ctrl_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;
    localparam int CNT_W  = 4;

    localparam logic [WORD_W-1:0] ZERO_WORD = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Expand one enable bit per byte lane into a full-word bit mask.
    function automatic logic [WORD_W-1:0] lane_mask(input logic [BE_W-1:0] be);
        logic [WORD_W-1:0] m;
        m = '0;
        for (int b = 0; b < BE_W; b++) begin
            m[8*b +: 8] = {8{be[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/data_ram_ctrl_ram_bank_be.sv
// rtl/data_ram_ctrl_ram_bank_be.sv - word array with byte-lane write port and registered read port
module ram_bank_be
    import data_ram_ctrl_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [BE_W-1:0]   be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              rd_en,
    input  logic              rd_zero,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [WORD_W-1:0] mask;

    assign mask = lane_mask(be);

    // Merge enabled lanes into the addressed word; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= (mem[addr] & ~mask) | (wdata & mask);
        end
    end

    // Read register: loads only on a read access, so it holds across writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= ZERO_WORD;
        end else if (rd_en) begin
            rdata <= rd_zero ? ZERO_WORD : mem[addr];
        end
    end

endmodule

// File: rtl/data_ram_ctrl.sv
// rtl/data_ram_ctrl.sv - data-memory responder with programmable wait states and stall request
module data_ram_ctrl
    import data_ram_ctrl_pkg::*;
#(
    parameter int          ADDR_W      = 10,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic [3:0]  we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ready_o,
    output logic        err_o,
    output logic        stall_o
);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [BE_W-1:0]    req_we;
    logic [31:2]        req_word;
    logic [WORD_W-1:0]  req_data;

    logic [31:0]        offset;
    logic [29:0]        word_off;
    logic               below_base;
    logic               above_top;
    logic               out_of_range;
    logic [ADDR_W-1:0]  index;
    logic               access;
    logic               wr_en;
    logic               rd_en;
    logic               unused_lsbs;

    // Range check and index are derived from the latched request only.
    assign offset       = {req_word, 2'b00} - BASE_ADDR;
    assign word_off     = offset[31:2];
    assign below_base   = {req_word, 2'b00} < BASE_ADDR;
    assign above_top    = (word_off >> ADDR_W) != '0;
    assign out_of_range = below_base | above_top;
    assign index        = word_off[ADDR_W-1:0];
    assign unused_lsbs  = ^{addr_i[1:0], offset[1:0]};

    // The access edge is the last BUSY edge; writes out of range are dropped.
    assign access = (state == ST_BUSY) && (cnt == '0);
    assign wr_en  = access && (req_we != '0) && !out_of_range;
    assign rd_en  = access && (req_we == '0);

    // Requester is held while it asks and the completion pulse has not arrived.
    assign stall_o = ce_i & ~ready_o;

    ram_bank_be #(
        .ADDR_W (ADDR_W)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .be      (req_we),
        .addr    (index),
        .wdata   (req_data),
        .rd_en   (rd_en),
        .rd_zero (out_of_range),
        .rdata   (data_o)
    );

    // Request FSM: accept and latch, count wait states, pulse ready/err for one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            req_we   <= '0;
            req_word <= '0;
            req_data <= ZERO_WORD;
            ready_o  <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ready_o <= 1'b0;
                    err_o   <= 1'b0;
                    if (ce_i) begin
                        req_we   <= we_i;
                        req_word <= addr_i[31:2];
                        req_data <= data_i;
                        cnt      <= CNT_W'(WAIT_CYCLES);
                        state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (cnt == '0) begin
                        ready_o <= 1'b1;
                        err_o   <= out_of_range;
                        state   <= ST_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    ready_o <= 1'b0;
                    err_o   <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    ready_o <= 1'b0;
                    err_o   <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_ram_ctrl.sv
// tb/tb_data_ram_ctrl.sv - scoreboard bench for data_ram_ctrl
module tb_data_ram_ctrl;

    localparam int WAIT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce_i = 1'b0;
    logic [3:0]  we_i = 4'h0;
    logic [31:0] addr_i = 32'h0;
    logic [31:0] data_i = 32'h0;
    logic [31:0] data_o;
    logic        ready_o;
    logic        err_o;
    logic        stall_o;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [0:1023];
    logic [31:0] last_data = 32'h0;

    always #5 clk = ~clk;

    data_ram_ctrl #(
        .ADDR_W      (10),
        .WAIT_CYCLES (WAIT),
        .BASE_ADDR   (32'h0000_0000)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ce_i    (ce_i),
        .we_i    (we_i),
        .addr_i  (addr_i),
        .data_i  (data_i),
        .data_o  (data_o),
        .ready_o (ready_o),
        .err_o   (err_o),
        .stall_o (stall_o)
    );

    // Reference memory: apply the request and return the expected completion.
    function automatic exp_t model_access(logic [3:0] we, logic [31:0] addr, logic [31:0] d);
        exp_t e;
        logic oor;
        int idx;
        oor = addr >= 32'h0000_1000;
        idx = int'(addr[11:2]);
        if (we == 4'h0) begin
            last_data = oor ? 32'h0 : model[idx];
        end else if (!oor) begin
            for (int b = 0; b < 4; b++) begin
                if (we[b]) model[idx][8*b +: 8] = d[8*b +: 8];
            end
        end
        e.data = last_data;
        e.err  = oor;
        return e;
    endfunction

    // Present a request and wait for ready_o; sampled 1 time unit after each edge.
    task automatic run_req(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] d,
                           input int drop_at, output logic [31:0] rd, output logic er,
                           output int lat, output int stalls, output logic stall_rdy, output bit to);
        ce_i = 1'b1; we_i = we; addr_i = addr; data_i = d;
        stalls = 0; lat = -1; to = 1'b1; rd = 32'h0; er = 1'b0; stall_rdy = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (k == drop_at) ce_i = 1'b0;
            if (ready_o) begin
                rd = data_o; er = err_o; lat = k; stall_rdy = stall_o; to = 1'b0;
                break;
            end
            stalls += int'(stall_o);
        end
        ce_i = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (data_o !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=%h", data_o, 32'h0); end
        checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ready_o); end
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_o); end
        checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall_o); end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_word_rw();
        logic [31:0] rd; logic er; int lat; int st; logic sr; bit to; exp_t e;
        sb.push_back(model_access(4'hF, 32'h10, 32'h1122_3344));
        run_req(4'hF, 32'h10, 32'h1122_3344, -1, rd, er, lat, st, sr, to);
        e = sb.pop_front();
        checks++; if (to) begin failures++; $display("FAIL word_wr_timeout got=none exp=ready"); end
        checks++; if (lat != WAIT + 1) begin failures++; $display("FAIL word_wr_latency got=%0d exp=%0d", lat, WAIT + 1); end
        checks++; if (st != WAIT + 1) begin failures++; $display("FAIL word_wr_stall_cycles got=%0d exp=%0d", st, WAIT + 1); end
        checks++; if (sr !== 1'b0) begin failures++; $display("FAIL word_wr_stall_at_ready got=%b exp=0", sr); end
        checks++; if (rd !== e.data || er !== e.err) begin failures++; $display("FAIL word_wr_hold got=%h/%b exp=%h/%b", rd, er, e.data, e.err); end
        @(posedge clk); #1;
        checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL ready_one_cycle got=%b exp=0", ready_o); end
        sb.push_back(model_access(4'h0, 32'h10, 32'h0));
        run_req(4'h0, 32'h10, 32'h0, -1, rd, er, lat, st, sr, to);
        e = sb.pop_front();
        checks++; if (to || rd !== e.data || er !== e.err) begin failures++; $display("FAIL word_rd got=%h/%b exp=%h/%b", rd, er, e.data, e.err); end
        @(posedge clk); #1;
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd; logic er; int lat; int st; logic sr; bit to; exp_t e;
        sb.push_back(model_access(4'b0010, 32'h10, 32'hAABB_CCDD));
        run_req(4'b0010, 32'h10, 32'hAABB_CCDD, -1, rd, er, lat, st, sr, to);
        e = sb.pop_front();
        checks++; if (to || rd !== e.data || er !== e.err) begin failures++; $display("FAIL lane_wr got=%h/%b exp=%h/%b", rd, er, e.data, e.err); end
        @(posedge clk); #1;
        sb.push_back(model_access(4'h0, 32'h10, 32'h0));
        run_req(4'h0, 32'h10, 32'h0, -1, rd, er, lat, st, sr, to);
        e = sb.pop_front();
        checks++; if (to || rd !== e.data) begin failures++; $display("FAIL lane_rd got=%h exp=%h", rd, e.data); end
        checks++; if (rd !== 32'h1122_CC44) begin failures++; $display("FAIL lane_rd_const got=%h exp=%h", rd, 32'h1122_CC44); end
        @(posedge clk); #1;
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd; logic er; int lat; int st; logic sr; bit to; exp_t e;
        logic [3:0]  we_t   [4] = '{4'hF, 4'hF, 4'h0, 4'h0};
        logic [31:0] addr_t [4] = '{32'h0, 32'h1000, 32'h1000, 32'h0};
        logic [31:0] data_t [4] = '{32'hCAFE_F00D, 32'hBAD0_BAD0, 32'h0, 32'h0};
        for (int i = 0; i < 4; i++) begin
            sb.push_back(model_access(we_t[i], addr_t[i], data_t[i]));
            run_req(we_t[i], addr_t[i], data_t[i], -1, rd, er, lat, st, sr, to);
            e = sb.pop_front();
            checks++;
            if (to || rd !== e.data || er !== e.err) begin
                failures++;
                $display("FAIL oor_step%0d got=%h/%b exp=%h/%b", i, rd, er, e.data, e.err);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic er; int lat; int st; logic sr; bit to; exp_t e; int seen;
        sb.push_back(model_access(4'hF, 32'h20, 32'hDEAD_BEEF));
        run_req(4'hF, 32'h20, 32'hDEAD_BEEF, -1, rd, er, lat, st, sr, to);
        e = sb.pop_front();
        checks++; if (to || rd !== e.data) begin failures++; $display("FAIL abort_setup got=%h exp=%h", rd, e.data); end
        @(posedge clk); #1;
        ce_i = 1'b1; we_i = 4'hF; addr_i = 32'h20; data_i = 32'h1234_5678;
        @(posedge clk); #1;
        @(posedge clk); #3;
        ce_i = 1'b0;
        rst = 1'b0;
        #1;
        last_data = 32'h0;
        checks++; if (data_o !== 32'h0 || ready_o !== 1'b0 || err_o !== 1'b0 || stall_o !== 1'b0) begin
            failures++; $display("FAIL async_reset got=%h/%b/%b/%b exp=0/0/0/0", data_o, ready_o, err_o, stall_o);
        end
        #2 rst = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            seen += int'(ready_o);
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL abort_no_ready got=%0d exp=0", seen); end
        sb.push_back(model_access(4'h0, 32'h20, 32'h0));
        run_req(4'h0, 32'h20, 32'h0, -1, rd, er, lat, st, sr, to);
        e = sb.pop_front();
        checks++; if (to || rd !== e.data || rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL abort_rd got=%h exp=%h", rd, 32'hDEAD_BEEF); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int lat; int st; logic sr; bit to; exp_t e;
        sb.push_back(model_access(4'hF, 32'h30, 32'h5A5A_5A5A));
        run_req(4'hF, 32'h30, 32'h5A5A_5A5A, 0, rd, er, lat, st, sr, to);
        e = sb.pop_front();
        checks++; if (to) begin failures++; $display("FAIL ce_drop_ready got=none exp=ready"); end
        checks++; if (lat != WAIT + 1 || rd !== e.data || er !== e.err) begin
            failures++; $display("FAIL ce_drop_wr got=%0d/%h/%b exp=%0d/%h/%b", lat, rd, er, WAIT + 1, e.data, e.err);
        end
        sb.push_back(model_access(4'h0, 32'h30, 32'h0));
        run_req(4'h0, 32'h30, 32'h0, -1, rd, er, lat, st, sr, to);
        e = sb.pop_front();
        checks++; if (to || lat + 1 != WAIT + 3) begin failures++; $display("FAIL b2b_spacing got=%0d exp=%0d", lat + 1, WAIT + 3); end
        checks++; if (rd !== e.data || er !== e.err) begin failures++; $display("FAIL ce_drop_rd got=%h/%b exp=%h/%b", rd, er, e.data, e.err); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_byte_lanes();
        test_out_of_range();
        test_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
